// File: rtl/seq_mem_arbiter.sv
// seq_mem_arbiter: two-requester arbitrated word/bit memory with a power-up clear sweep
module seq_mem_arbiter #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic             a_we,
    input  logic             a_bit,
    input  logic [AW-1:0]    a_addr,
    input  logic [BW-1:0]    a_bit_index,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic [WIDTH-1:0] a_rdata,
    output logic             a_rvalid,
    input  logic             b_req,
    input  logic             b_we,
    input  logic             b_bit,
    input  logic [AW-1:0]    b_addr,
    input  logic [BW-1:0]    b_bit_index,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic [WIDTH-1:0] b_rdata,
    output logic             b_rvalid,
    output logic             busy
);
    typedef enum logic {INIT, RUN} state_e;
    state_e           state_q;
    logic [AW-1:0]    init_ptr_q;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] a_rdata_q, b_rdata_q;
    logic             a_rvalid_q, b_rvalid_q;
    logic             run, a_win, b_win, a_rd, b_rd, w_en;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_merged, w_data;

    assign run      = state_q == RUN;
    assign a_win    = run & a_req & (~b_req | ~prio_q);
    assign b_win    = run & b_req & (~a_req | prio_q);
    assign a_rd     = a_win & ~a_we & ~a_bit;
    assign b_rd     = b_win & ~b_we & ~b_bit;
    assign a_gnt    = a_win;
    assign b_gnt    = b_win;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign busy     = ~run;

    // Winner's write fields, bit writes merged into the current word, and next priority
    always_comb begin
        prio_d   = a_win ? 1'b1 : b_win ? 1'b0 : prio_q;
        w_en     = (a_win & (a_we | a_bit)) | (b_win & (b_we | b_bit));
        w_addr   = b_win ? b_addr : a_addr;
        w_merged = mem[w_addr];
        w_merged[b_win ? b_bit_index : a_bit_index] = b_win ? b_wdata[0] : a_wdata[0];
        w_data   = (b_win ? b_bit : a_bit) ? w_merged : (b_win ? b_wdata : a_wdata);
    end

    // Memory array: cleared word by word during the sweep, written by the winner in run
    always_ff @(posedge clk) begin
        if (!run)
            mem[init_ptr_q] <= '0;
        else if (w_en)
            mem[w_addr] <= w_data;
    end

    // Sweep/run FSM with priority toggle and registered read ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            prio_q     <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            a_rvalid_q <= a_rd;
            b_rvalid_q <= b_rd;
            if (a_rd)
                a_rdata_q <= mem[a_addr];
            if (b_rd)
                b_rdata_q <= mem[b_addr];
            if (!run) begin
                init_ptr_q <= init_ptr_q + 1'b1;
                if (init_ptr_q == AW'(DEPTH - 1))
                    state_q <= RUN;
            end
        end
    end
endmodule

// File: doc/seq_mem_arbiter.md
SEQ_MEM_ARBITER -- requirements
Module: seq_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 16: number of memory words; power of two, 2..256; AW = clog2(DEPTH).
REQ-002 Parameter WIDTH, default 8: word width; BW = clog2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 a_req  input  1  requester A access request.
REQ-006 a_we  input  1  1 = word write, 0 = read; ignored when a_bit=1.
REQ-007 a_bit  input  1  single-bit write; takes precedence over a_we.
REQ-008 a_addr  input  AW  word address.
REQ-009 a_bit_index  input  BW  bit position for bit write.
REQ-010 a_wdata  input  WIDTH  write data; bit write uses a_wdata[0].
REQ-011 a_gnt  output  1  access accepted this cycle.
REQ-012 a_rdata  output  WIDTH  read data for A.
REQ-013 a_rvalid  output  1  one-cycle pulse when a_rdata is updated.
REQ-014 Ports b_req, b_we, b_bit, b_addr, b_bit_index, b_wdata, b_gnt, b_rdata and b_rvalid SHALL be identical to the A ports, serving requester B.
REQ-015 busy  output  1  initialisation sweep in progress.

Function
REQ-016 The block SHALL own a DEPTH x WIDTH memory and SHALL implement a two-state FSM, INIT and RUN.
REQ-017 INIT: one write of 0 to mem[init_ptr] per cycle, init_ptr incremented; after the write to DEPTH-1, next state RUN. INIT lasts exactly DEPTH cycles.
REQ-018 busy SHALL be 1 in INIT and 0 in RUN; a_gnt and b_gnt SHALL be 0 in INIT regardless of req.
REQ-019 RUN: grants are combinational from req/prio/state; at most one of a_gnt or b_gnt is 1 per cycle.
REQ-020 Single requester: granted the same cycle. Both requesting: prio selects the winner (0 = A, 1 = B).
REQ-021 After any grant, prio SHALL be set to favour the non-winner; with no grant, prio holds.
REQ-022 Handshake: transfer occurs on a cycle with req=1 and gnt=1. The requester holds req and its fields stable until gnt. Dropping req before gnt has no side effect.
REQ-023 Word write: mem[addr] <= wdata at the grant edge.
REQ-024 Bit write: mem[addr][bit_index] <= wdata[0] at the grant edge; the other bits are unchanged.
REQ-025 Read: the granted requester's rdata <= mem[addr] at the grant edge, and its rvalid = 1 for exactly the next cycle. Latency is 1 cycle.
REQ-026 rdata SHALL hold its last read value until that requester's next read. Writes never pulse rvalid.
REQ-027 A read granted the cycle after a write to the same address SHALL return the newly written data, including bit-write results.
REQ-028 Back-to-back grants to the same requester are permitted when the other is idle; consecutive reads give consecutive rvalid pulses.
REQ-029 Fairness: a continuously requesting requester SHALL be granted within 2 RUN cycles.

Reset
REQ-030 While rst=1, asynchronously: state=INIT, init_ptr=0, prio=0, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, busy=1.
REQ-031 Memory contents SHALL NOT be asynchronously reset; they are cleared only by the INIT sweep.
REQ-032 rst asserted mid-INIT or mid-RUN SHALL abort the operation in flight and restart the full DEPTH-cycle sweep. A read granted in the reset cycle produces no rvalid.
REQ-033 After rst deasserts, the first grant SHALL occur no earlier than DEPTH cycles later.

Verification
REQ-034 Reset release, DEPTH=16 -> busy=1 for exactly 16 cycles. Reads of addresses 0..15 then return 0x00.
REQ-035 A word-writes addr 3 = 0xA5, next cycle B reads addr 3 -> b_rvalid=1 one cycle after b_gnt, with b_rdata=0xA5.
REQ-036 A and B request continuously after init -> grant sequence A,B,A,B...; neither starves.
REQ-037 mem[5]=0x0F, A bit-writes addr 5 index 7 with wdata[0]=1 -> subsequent read returns 0x8F.
REQ-038 rst pulsed at sweep cycle 8 with a_req=1 held -> busy stays 1 for 16 cycles after release, and no a_gnt during that window.
REQ-039 A reads addr 1 (0x11) then addr 2 (0x22) back-to-back -> a_rvalid high two consecutive cycles, with a_rdata 0x11 then 0x22.
